// File: rtl/sram_dp_pkg.sv
// Shared constants and FSM encoding for the dual-port SRAM controller.
package sram_dp_pkg;

  // Cross-port read-during-write result selection.
  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  // Winner of a same-address dual write.
  localparam int unsigned PRIO_A = 0;
  localparam int unsigned PRIO_B = 1;

  // Clear-sweep controller states.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } init_state_e;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result output stage: one register stage for RD_LAT = 1, two for RD_LAT = 2.
// Data only moves with its valid bit, so the output holds the last result between pulses.
module sram_rd_pipe
  import sram_dp_pkg::*;
#(
  parameter int unsigned DW     = 24,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_v1;
  logic [DW-1:0] r_d1;

  // First stage: capture the array word on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) r_d1 <= i_data;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          r_v2;
      logic [DW-1:0] r_d2;

      // Second stage: extra output register for the two-cycle latency build.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign o_valid = r_v2;
      assign o_data  = r_d2;
    end else begin : g_lat1
      assign o_valid = r_v1;
      assign o_data  = r_d1;
    end
  endgenerate

endmodule

// File: rtl/sram_dp_ctrl.sv
// True dual-port SRAM with clear-after-reset sweep, defined read-during-write
// behaviour and same-address write collision detection/counting.
module sram_dp_ctrl
  import sram_dp_pkg::*;
#(
  parameter int unsigned DW         = 24,
  parameter int unsigned AW         = 10,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned WR_PRIO    = 0,
  parameter int unsigned INIT_CLEAR = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             SRAM_CS_A_N,
  input  logic             SRAM_WE_A_N,
  input  logic [AW-1:0]    SRAM_ADDR_A,
  input  logic [DW-1:0]    SRAM_WDATA_A,
  output logic [DW-1:0]    SRAM_RDATA_A,
  output logic             SRAM_RVALID_A,
  input  logic             SRAM_CS_B_N,
  input  logic             SRAM_WE_B_N,
  input  logic [AW-1:0]    SRAM_ADDR_B,
  input  logic [DW-1:0]    SRAM_WDATA_B,
  output logic [DW-1:0]    SRAM_RDATA_B,
  output logic             SRAM_RVALID_B,
  output logic             init_busy,
  output logic             collision,
  output logic [CNT_W-1:0] collision_cnt,
  input  logic             clr_cnt
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];

  init_state_e   r_state;
  init_state_e   w_state_nxt;
  logic [AW-1:0] r_sweep_addr;
  logic          w_busy;

  logic          w_acc_a, w_acc_b;
  logic          w_wr_a, w_wr_b, w_rd_a, w_rd_b;
  logic          w_same_addr, w_coll;
  logic          w_store_a, w_store_b;
  logic          w_we_a;
  logic [AW-1:0] w_waddr_a;
  logic [DW-1:0] w_wdata_a;
  logic [DW-1:0] w_rdata_a, w_rdata_b;

  logic             r_coll;
  logic [CNT_W-1:0] r_cnt;

  // Init FSM state register; without the clear sweep the block starts ready.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      if (INIT_CLEAR != 0) r_state <= ST_INIT;
      else                 r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sweep address advances one word per cycle while clearing.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)                r_sweep_addr <= '0;
    else if (r_state == ST_INIT) r_sweep_addr <= r_sweep_addr + 1'b1;
  end

  // Leave INIT right after the last word has been cleared.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && (&r_sweep_addr)) w_state_nxt = ST_RUN;
  end

  // Busy flag doubles as the sweep write strobe.
  always_comb begin
    w_busy = (r_state == ST_INIT);
  end

  assign init_busy = w_busy;

  assign w_acc_a     = !SRAM_CS_A_N && !w_busy;
  assign w_acc_b     = !SRAM_CS_B_N && !w_busy;
  assign w_wr_a      = w_acc_a && !SRAM_WE_A_N;
  assign w_wr_b      = w_acc_b && !SRAM_WE_B_N;
  assign w_rd_a      = w_acc_a && SRAM_WE_A_N;
  assign w_rd_b      = w_acc_b && SRAM_WE_B_N;
  assign w_same_addr = (SRAM_ADDR_A == SRAM_ADDR_B);
  assign w_coll      = w_wr_a && w_wr_b && w_same_addr;
  assign w_store_a   = w_wr_a && !(w_coll && WR_PRIO == PRIO_B);
  assign w_store_b   = w_wr_b && !(w_coll && WR_PRIO == PRIO_A);

  // The sweep borrows write port A: user accesses are blocked while it runs,
  // so the array keeps exactly two write ports.
  assign w_we_a    = w_busy || w_store_a;
  assign w_waddr_a = w_busy ? r_sweep_addr : SRAM_ADDR_A;
  assign w_wdata_a = w_busy ? '0 : SRAM_WDATA_A;

  // Array writes; contents are deliberately not reset.
  always_ff @(posedge clk_100m) begin
    if (w_we_a)    r_mem[w_waddr_a]   <= w_wdata_a;
    if (w_store_b) r_mem[SRAM_ADDR_B] <= SRAM_WDATA_B;
  end

  // Read word per port, forwarding the other port's write in new-data mode.
  always_comb begin
    w_rdata_a = r_mem[SRAM_ADDR_A];
    w_rdata_b = r_mem[SRAM_ADDR_B];
    if (RDW_MODE != RDW_OLD) begin
      if (w_store_b && w_same_addr) w_rdata_a = SRAM_WDATA_B;
      if (w_store_a && w_same_addr) w_rdata_b = SRAM_WDATA_A;
    end
  end

  sram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk     (clk_100m),
    .rst_n   (rst_n),
    .i_valid (w_rd_a),
    .i_data  (w_rdata_a),
    .o_valid (SRAM_RVALID_A),
    .o_data  (SRAM_RDATA_A)
  );

  sram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk     (clk_100m),
    .rst_n   (rst_n),
    .i_valid (w_rd_b),
    .i_data  (w_rdata_b),
    .o_valid (SRAM_RVALID_B),
    .o_data  (SRAM_RDATA_B)
  );

  // Collision pulse and saturating counter; a clear coinciding with a collision leaves 1.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_coll <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_coll <= w_coll;
      if (clr_cnt)                     r_cnt <= w_coll ? CNT_W'(1) : '0;
      else if (w_coll && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
    end
  end

  assign collision     = r_coll;
  assign collision_cnt = r_cnt;

endmodule

// File: tb/tb_sram_dp_ctrl.sv
// Bench for sram_dp_ctrl: two builds (default, and RD_LAT=2/new-data/B-priority/4-bit
// counter) share one stimulus stream and are checked against a behavioural model.
module tb_sram_dp_ctrl;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_a_n = 1'b1, we_a_n = 1'b1, cs_b_n = 1'b1, we_b_n = 1'b1;
  logic [9:0]  addr_a = '0, addr_b = '0;
  logic [23:0] wdata_a = '0, wdata_b = '0;
  logic        clr_cnt = 1'b0;

  logic [23:0] o0_rd_a, o0_rd_b, o1_rd_a, o1_rd_b;
  logic        o0_v_a, o0_v_b, o1_v_a, o1_v_b;
  logic        o0_busy, o1_busy, o0_coll, o1_coll;
  logic [7:0]  o0_cnt;
  logic [3:0]  o1_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  sram_dp_ctrl dut0 (
    .clk_100m(clk), .rst_n(rst_n),
    .SRAM_CS_A_N(cs_a_n), .SRAM_WE_A_N(we_a_n), .SRAM_ADDR_A(addr_a), .SRAM_WDATA_A(wdata_a),
    .SRAM_RDATA_A(o0_rd_a), .SRAM_RVALID_A(o0_v_a),
    .SRAM_CS_B_N(cs_b_n), .SRAM_WE_B_N(we_b_n), .SRAM_ADDR_B(addr_b), .SRAM_WDATA_B(wdata_b),
    .SRAM_RDATA_B(o0_rd_b), .SRAM_RVALID_B(o0_v_b),
    .init_busy(o0_busy), .collision(o0_coll), .collision_cnt(o0_cnt), .clr_cnt(clr_cnt)
  );

  sram_dp_ctrl #(.RD_LAT(2), .RDW_MODE(1), .WR_PRIO(1), .CNT_W(4)) dut1 (
    .clk_100m(clk), .rst_n(rst_n),
    .SRAM_CS_A_N(cs_a_n), .SRAM_WE_A_N(we_a_n), .SRAM_ADDR_A(addr_a), .SRAM_WDATA_A(wdata_a),
    .SRAM_RDATA_A(o1_rd_a), .SRAM_RVALID_A(o1_v_a),
    .SRAM_CS_B_N(cs_b_n), .SRAM_WE_B_N(we_b_n), .SRAM_ADDR_B(addr_b), .SRAM_WDATA_B(wdata_b),
    .SRAM_RDATA_B(o1_rd_b), .SRAM_RVALID_B(o1_v_b),
    .init_busy(o1_busy), .collision(o1_coll), .collision_cnt(o1_cnt), .clr_cnt(clr_cnt)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int unsigned due;
    logic [23:0] d;
  } pend_t;

  pend_t       pq [4][$];          // pending read results: index 2*dut + port
  logic [23:0] mm [2][DEPTH];
  int unsigned since = 0;          // edges since reset release, stops at DEPTH
  int unsigned ecnt = 0;
  logic        ebusy = 1'b1;
  logic        ev_a [2], ev_b [2], ec [2];
  logic [23:0] ed_a [2], ed_b [2];
  int unsigned ecc [2];

  task automatic model_reset();
    since = 0;
    ebusy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ev_a[d] = 1'b0; ev_b[d] = 1'b0; ec[d] = 1'b0;
      ed_a[d] = '0;   ed_b[d] = '0;   ecc[d] = 0;
    end
    for (int q = 0; q < 4; q++) pq[q].delete();
  endtask

  task automatic model_pop(input int q, output logic v, inout logic [23:0] dv);
    pend_t p;
    v = 1'b0;
    if (pq[q].size() > 0 && pq[q][0].due == ecnt) begin
      p  = pq[q].pop_front();
      v  = 1'b1;
      dv = p.d;
    end
  endtask

  task automatic model_edge();
    logic busy0, ra, rb, wa, wb, same, coll, newd, prb;
    int unsigned lat, mx;
    pend_t p;
    ecnt++;
    busy0 = (since < DEPTH);
    ra   = !cs_a_n && !busy0 && we_a_n;
    wa   = !cs_a_n && !busy0 && !we_a_n;
    rb   = !cs_b_n && !busy0 && we_b_n;
    wb   = !cs_b_n && !busy0 && !we_b_n;
    same = (addr_a == addr_b);
    coll = wa && wb && same;
    for (int d = 0; d < 2; d++) begin
      lat  = (d == 0) ? 1 : 2;
      newd = (d == 1);
      prb  = (d == 1);
      mx   = (d == 0) ? 255 : 15;
      if (ra) begin
        p.due = ecnt + lat - 1;
        p.d   = (newd && wb && same) ? wdata_b : mm[d][addr_a];
        pq[2*d].push_back(p);
      end
      if (rb) begin
        p.due = ecnt + lat - 1;
        p.d   = (newd && wa && same) ? wdata_a : mm[d][addr_b];
        pq[2*d+1].push_back(p);
      end
      if (busy0) mm[d][since] = '0;
      if (coll) mm[d][addr_a] = prb ? wdata_b : wdata_a;
      else begin
        if (wa) mm[d][addr_a] = wdata_a;
        if (wb) mm[d][addr_b] = wdata_b;
      end
      if (clr_cnt)               ecc[d] = coll ? 1 : 0;
      else if (coll && ecc[d] < mx) ecc[d] = ecc[d] + 1;
      ec[d] = coll;
      model_pop(2*d,   ev_a[d], ed_a[d]);
      model_pop(2*d+1, ev_b[d], ed_b[d]);
    end
    if (busy0) since++;
    ebusy = (since < DEPTH);
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_edge();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both builds against the model.
  always begin
    @(posedge clk);
    #1;
    chk("d0_rvalid_a", 32'(o0_v_a), 32'(ev_a[0]));
    chk("d0_rvalid_b", 32'(o0_v_b), 32'(ev_b[0]));
    chk("d0_rdata_a",  32'(o0_rd_a), 32'(ed_a[0]));
    chk("d0_rdata_b",  32'(o0_rd_b), 32'(ed_b[0]));
    chk("d0_busy",     32'(o0_busy), 32'(ebusy));
    chk("d0_coll",     32'(o0_coll), 32'(ec[0]));
    chk("d0_cnt",      32'(o0_cnt),  ecc[0]);
    chk("d1_rvalid_a", 32'(o1_v_a), 32'(ev_a[1]));
    chk("d1_rvalid_b", 32'(o1_v_b), 32'(ev_b[1]));
    chk("d1_rdata_a",  32'(o1_rd_a), 32'(ed_a[1]));
    chk("d1_rdata_b",  32'(o1_rd_b), 32'(ed_b[1]));
    chk("d1_busy",     32'(o1_busy), 32'(ebusy));
    chk("d1_coll",     32'(o1_coll), 32'(ec[1]));
    chk("d1_cnt",      32'(o1_cnt),  ecc[1]);
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic idle();
    cs_a_n = 1'b1; we_a_n = 1'b1; cs_b_n = 1'b1; we_b_n = 1'b1; clr_cnt = 1'b0;
  endtask

  task automatic wr_a(input logic [9:0] a, input logic [23:0] d);
    cs_a_n = 1'b0; we_a_n = 1'b0; addr_a = a; wdata_a = d;
  endtask

  task automatic wr_b(input logic [9:0] a, input logic [23:0] d);
    cs_b_n = 1'b0; we_b_n = 1'b0; addr_b = a; wdata_b = d;
  endtask

  // Read on A; returns dut0 result one cycle later and dut1 result two cycles later.
  task automatic rd_a(input logic [9:0] a, output logic v0, output logic [23:0] d0,
                      output logic v1, output logic [23:0] d1);
    cs_a_n = 1'b0; we_a_n = 1'b1; addr_a = a;
    @(negedge clk);
    idle();
    v0 = o0_v_a; d0 = o0_rd_a;
    @(negedge clk);
    v1 = o1_v_a; d1 = o1_rd_a;
  endtask

  // Count falling edges with init_busy high, starting at the current one.
  task automatic count_busy(output int unsigned nb);
    nb = 0;
    while (o0_busy && nb < 2000) begin
      if (nb == 10)        wr_a(10'd5, 24'hABCDEF);
      else if (nb == 20) begin cs_a_n = 1'b0; we_a_n = 1'b1; addr_a = 10'd5;
                               cs_b_n = 1'b0; we_b_n = 1'b1; addr_b = 10'd9; end
      else if (nb == 1023) wr_a(10'd6, 24'h123456);
      else                 idle();
      @(negedge clk);
      nb++;
    end
    idle();
  endtask

  logic        v0, v1;
  logic [23:0] d0, d1;
  int unsigned nb;
  logic        hv [20];
  logic [23:0] hd [20];
  int unsigned pulses;

  initial begin
    idle();
    repeat (3) @(negedge clk);

    // Init sweep with dropped accesses, including one on the final busy cycle.
    rst_n = 1'b1;
    count_busy(nb);
    chk("init_busy_cycles", nb, 1024);

    rd_a(10'd0, v0, d0, v1, d1);
    chk("rd0_v0", 32'(v0), 1); chk("rd0_d0", 32'(d0), 32'h0); chk("rd0_d1", 32'(d1), 32'h0);
    rd_a(10'd511, v0, d0, v1, d1);
    chk("rd511_v0", 32'(v0), 1); chk("rd511_d0", 32'(d0), 32'h0);
    rd_a(10'd1023, v0, d0, v1, d1);
    chk("rd1023_v0", 32'(v0), 1); chk("rd1023_d0", 32'(d0), 32'h0); chk("rd1023_v1", 32'(v1), 1);
    rd_a(10'd5, v0, d0, v1, d1);
    chk("dropped5_d0", 32'(d0), 32'h0); chk("dropped5_d1", 32'(d1), 32'h0);
    rd_a(10'd6, v0, d0, v1, d1);
    chk("dropped6_d0", 32'(d0), 32'h0);

    // Cross-port read-during-write on address 7.
    wr_a(10'd7, 24'h111111);
    @(negedge clk); idle();
    wr_a(10'd7, 24'h222222);
    cs_b_n = 1'b0; we_b_n = 1'b1; addr_b = 10'd7;
    @(negedge clk); idle();
    chk("rdw_old_d0", 32'(o0_rd_b), 32'h111111);
    @(negedge clk);
    chk("rdw_new_d1", 32'(o1_rd_b), 32'h222222);
    rd_a(10'd7, v0, d0, v1, d1);
    chk("rdw_after_d0", 32'(d0), 32'h222222); chk("rdw_after_d1", 32'(d1), 32'h222222);

    // Same-address dual write.
    wr_a(10'd3, 24'hAAAAAA); wr_b(10'd3, 24'hBBBBBB);
    @(negedge clk); idle();
    chk("coll_pulse_d0", 32'(o0_coll), 1); chk("coll_cnt_d0", 32'(o0_cnt), 1);
    chk("coll_pulse_d1", 32'(o1_coll), 1);
    @(negedge clk);
    chk("coll_end_d0", 32'(o0_coll), 0);
    rd_a(10'd3, v0, d0, v1, d1);
    chk("coll_prioA", 32'(d0), 32'hAAAAAA); chk("coll_prioB", 32'(d1), 32'hBBBBBB);
    for (int i = 0; i < 299; i++) begin
      wr_a(10'd3, 24'hAAAAAA); wr_b(10'd3, 24'hBBBBBB);
      @(negedge clk);
    end
    idle();
    chk("sat_d0", 32'(o0_cnt), 255); chk("sat_d1", 32'(o1_cnt), 15);
    clr_cnt = 1'b1;
    @(negedge clk); idle();
    chk("clr_d0", 32'(o0_cnt), 0);
    clr_cnt = 1'b1; wr_a(10'd3, 24'h1); wr_b(10'd3, 24'h2);
    @(negedge clk); idle();
    chk("clr_and_coll_d0", 32'(o0_cnt), 1); chk("clr_and_coll_d1", 32'(o1_cnt), 1);

    // Dual write to different addresses, then preload addr*3 for streaming.
    for (int i = 0; i < 16; i += 2) begin
      wr_a(10'(i), 24'(i * 3)); wr_b(10'(i + 1), 24'((i + 1) * 3));
      @(negedge clk);
    end
    idle();
    for (int k = 0; k < 20; k++) begin
      if (k < 16) begin cs_b_n = 1'b0; we_b_n = 1'b1; addr_b = 10'(k); end
      else idle();
      @(negedge clk);
      hv[k] = o1_v_b; hd[k] = o1_rd_b;
    end
    idle();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      chk("stream_v_d1", 32'(hv[k]), (k >= 1 && k <= 16) ? 1 : 0);
      if (hv[k]) begin
        pulses++;
        chk("stream_d_d1", 32'(hd[k]), 32'((k - 1) * 3));
      end
    end
    chk("stream_pulses", pulses, 16);

    // Randomised traffic, mostly on a small window to provoke collisions and RDW.
    for (int i = 0; i < 3000; i++) begin
      cs_a_n  = ($urandom_range(0, 3) == 0);
      we_a_n  = 1'($urandom_range(0, 1));
      cs_b_n  = ($urandom_range(0, 3) == 0);
      we_b_n  = 1'($urandom_range(0, 1));
      addr_a  = ((i % 512) < 400) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      addr_b  = ((i % 512) < 400) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      wdata_a = 24'($urandom);
      wdata_b = 24'($urandom);
      clr_cnt = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    idle();

    // Reset during a read burst.
    for (int i = 0; i < 5; i++) begin
      cs_a_n = 1'b0; we_a_n = 1'b1; addr_a = 10'($urandom_range(0, 15));
      cs_b_n = 1'b0; we_b_n = 1'b1; addr_b = 10'($urandom_range(0, 15));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_v_a_d0", 32'(o0_v_a), 0); chk("rst_v_b_d0", 32'(o0_v_b), 0);
    chk("rst_v_a_d1", 32'(o1_v_a), 0); chk("rst_v_b_d1", 32'(o1_v_b), 0);
    chk("rst_busy", 32'(o0_busy), 1);
    @(negedge clk); idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset halfway through the sweep, then a full sweep must follow.
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy(nb);
    chk("resweep_cycles", nb, 1024);
    rd_a(10'd7, v0, d0, v1, d1);
    chk("resweep_rd7_d0", 32'(d0), 32'h0); chk("resweep_rd7_d1", 32'(d1), 32'h0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
